// File: rtl/sram_bank_arbiter_pkg.sv
// Shared sizes and payload types for the multi-bank frame-buffer SRAM arbiter.
package sram_bank_arbiter_pkg;

    localparam int unsigned NUM_CLIENTS  = 4;
    localparam int unsigned NUM_BANKS    = 2;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned DATA_W       = 36;
    localparam int unsigned OFF_W        = 17;
    localparam int unsigned IMAGE_LENGTH = 76800;
    localparam int unsigned READ_LATENCY = 2;

    localparam int unsigned ORD_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned PIPE_D = 1 + READ_LATENCY;

    // One return-pipeline slot; zero marks an out-of-range read answered with 0.
    typedef struct packed {
        logic             valid;
        logic             zero;
        logic [ORD_W-1:0] id;
    } ret_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Client-side and SRAM-side signal bundle of the bank arbiter.
interface sram_bank_arbiter_if;
    import sram_bank_arbiter_pkg::*;

    logic                                   frame_flag;
    logic [NUM_CLIENTS-1:0]                 client_req;
    logic [NUM_CLIENTS-1:0]                 client_wr;
    logic [NUM_CLIENTS-1:0][OFF_W-1:0]      client_offset;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0]     client_wdata;
    logic [NUM_CLIENTS-1:0]                 client_gnt;
    logic [NUM_CLIENTS-1:0]                 client_rvalid;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0]     client_rdata;
    logic [NUM_CLIENTS-1:0]                 err_oob;
    logic [ORD_W-1:0]                       frame_idx;
    logic [NUM_BANKS-1:0]                   mem_en;
    logic [NUM_BANKS-1:0]                   mem_we;
    logic [NUM_BANKS-1:0][ADDR_W-1:0]       mem_addr;
    logic [NUM_BANKS-1:0][DATA_W-1:0]       mem_wdata;
    logic [NUM_BANKS-1:0][DATA_W-1:0]       mem_rdata;

    modport slave (
        input  frame_flag, client_req, client_wr, client_offset, client_wdata, mem_rdata,
        output client_gnt, client_rvalid, client_rdata, err_oob, frame_idx,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output frame_flag, client_req, client_wr, client_offset, client_wdata, mem_rdata,
        input  client_gnt, client_rvalid, client_rdata, err_oob, frame_idx,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram_bank_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at/after ptr wins, pointer advances past it.
module sram_bank_arbiter_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        idx      = 0;
        found    = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!found && req[PW'(idx)]) begin
                gnt[PW'(idx)] = 1'b1;
                next_ptr      = PW'((idx + 1) % N);
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares NUM_BANKS SRAM banks among role-bound clients with rotating frame buffers,
// per-bank round-robin arbitration and tagged fixed-latency read return.
module sram_bank_arbiter
    import sram_bank_arbiter_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    sram_bank_arbiter_if.slave  bus
);

    logic [ORD_W-1:0]                   frame_idx_q, frame_idx_d;
    logic [NUM_CLIENTS-1:0]             err_oob_q, err_oob_d;
    logic [NUM_CLIENTS-1:0]             client_rvalid_q, client_rvalid_d;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] client_rdata_q, client_rdata_d;

    logic [BANK_W-1:0]                  bank_sel [NUM_CLIENTS];
    logic [ADDR_W-1:0]                  addr_map [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0]             oob;
    logic [NUM_BANKS-1:0][NUM_CLIENTS-1:0] gnt_all;
    ret_t [NUM_BANKS-1:0]               ret_all;
    logic [NUM_CLIENTS-1:0]             gnt_c;

    // Role -> buffer -> (bank, slot) under the current rotation.
    always_comb begin
        int unsigned b;
        b   = 0;
        oob = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            b           = (i + 32'(frame_idx_q)) % NUM_CLIENTS;
            bank_sel[i] = BANK_W'(b % NUM_BANKS);
            addr_map[i] = ADDR_W'((b / NUM_BANKS) * IMAGE_LENGTH + 32'(bus.client_offset[i]));
            oob[i]      = 32'(bus.client_offset[i]) >= IMAGE_LENGTH;
        end
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [NUM_CLIENTS-1:0] req, gnt;
        logic [ORD_W-1:0]       ptr_q, ptr_d;
        mem_cmd_t               cmd_q, cmd_d;
        ret_t [PIPE_D-1:0]      pipe_q, pipe_d;
        ret_t                   push;

        always_comb begin
            req = '0;
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                req[i] = bus.client_req[i] && (bank_sel[i] == BANK_W'(k)) && !reset;
            end
        end

        sram_bank_arbiter_rr_arbiter #(.N(NUM_CLIENTS), .PW(ORD_W)) u_rr (
            .req      (req),
            .ptr      (ptr_q),
            .gnt      (gnt),
            .next_ptr (ptr_d)
        );

        // Out-of-range winners get no SRAM command but still occupy a return slot.
        always_comb begin
            cmd_d = '0;
            push  = '0;
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (gnt[i]) begin
                    cmd_d.en    = !oob[i];
                    cmd_d.we    = bus.client_wr[i] && !oob[i];
                    cmd_d.addr  = addr_map[i];
                    cmd_d.wdata = bus.client_wdata[i];
                    push.valid  = !bus.client_wr[i];
                    push.zero   = oob[i];
                    push.id     = ORD_W'(i);
                end
            end
            pipe_d[0] = push;
            for (int unsigned j = 1; j < PIPE_D; j++) begin
                pipe_d[j] = pipe_q[j-1];
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                ptr_q  <= '0;
                cmd_q  <= '0;
                pipe_q <= '0;
            end else begin
                ptr_q  <= ptr_d;
                cmd_q  <= cmd_d;
                pipe_q <= pipe_d;
            end
        end

        assign bus.mem_en[k]    = cmd_q.en;
        assign bus.mem_we[k]    = cmd_q.we;
        assign bus.mem_addr[k]  = cmd_q.addr;
        assign bus.mem_wdata[k] = cmd_q.wdata;
        assign gnt_all[k]       = gnt;
        assign ret_all[k]       = pipe_q[READ_LATENCY];
    end

    always_comb begin
        gnt_c           = '0;
        client_rvalid_d = '0;
        client_rdata_d  = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            gnt_c = gnt_c | gnt_all[k];
            for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
                if (ret_all[k].valid && (ret_all[k].id == ORD_W'(c))) begin
                    client_rvalid_d[c] = 1'b1;
                    if (!ret_all[k].zero) begin
                        client_rdata_d[c] = bus.mem_rdata[k];
                    end
                end
            end
        end
        err_oob_d   = err_oob_q | (gnt_c & oob);
        frame_idx_d = frame_idx_q;
        if (bus.frame_flag) begin
            frame_idx_d = (32'(frame_idx_q) == NUM_CLIENTS - 1) ? '0 : frame_idx_q + ORD_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_idx_q     <= '0;
            err_oob_q       <= '0;
            client_rvalid_q <= '0;
            client_rdata_q  <= '0;
        end else begin
            frame_idx_q     <= frame_idx_d;
            err_oob_q       <= err_oob_d;
            client_rvalid_q <= client_rvalid_d;
            client_rdata_q  <= client_rdata_d;
        end
    end

    assign bus.client_gnt    = gnt_c;
    assign bus.client_rvalid = client_rvalid_q;
    assign bus.client_rdata  = client_rdata_q;
    assign bus.err_oob       = err_oob_q;
    assign bus.frame_idx     = frame_idx_q;

endmodule
